// File: rtl/icache_line_fill.sv
// icache_line_fill: reads one cache line from instruction memory word by word and hands it to the cache controller
module icache_line_fill #(
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 fill_req_i,
  input  logic [ADDR_WIDTH-1:0]                fill_addr_i,
  input  logic                                 abort_i,
  output logic                                 mem_rd_o,
  output logic [ADDR_WIDTH-1:0]                mem_addr_o,
  input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
  input  logic                                 mem_valid_i,
  output logic                                 busy_o,
  output logic                                 fill_done_o,
  output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] line_data_o
);
  localparam int OFF = $clog2(WORDS_PER_LINE * DATA_WIDTH / 8);
  localparam int CW  = $clog2(WORDS_PER_LINE);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [CW-1:0] LAST = CW'(WORDS_PER_LINE - 1);
  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
  state_t                               state_q;
  logic [CW-1:0]                        count_q;
  logic                                 mem_rd_q;
  logic                                 fill_done_q;
  logic [ADDR_WIDTH-1:0]                mem_addr_q;
  logic [WORDS_PER_LINE*DATA_WIDTH-1:0] line_q;
  logic [ADDR_WIDTH-1:0]                base;
  logic                                 take;
  assign base = fill_addr_i & ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1));
  // a word is only accepted while the request is on the bus, and abort discards it
  assign take = mem_rd_q & mem_valid_i & ~abort_i;
  assign mem_rd_o    = mem_rd_q;
  assign mem_addr_o  = mem_addr_q;
  assign busy_o      = state_q != IDLE;
  assign fill_done_o = fill_done_q;
  assign line_data_o = line_q;
  // fill FSM: first READ cycle raises mem_rd, then one word per mem_valid until the line is full
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mem_rd_q    <= 1'b0;
      fill_done_q <= 1'b0;
      mem_addr_q  <= '0;
      line_q      <= '0;
    end else begin
      fill_done_q <= 1'b0;
      case (state_q)
        IDLE: if (fill_req_i) begin
          state_q    <= READ;
          count_q    <= '0;
          mem_addr_q <= base;
        end
        READ: if (abort_i) begin
          state_q  <= IDLE;
          mem_rd_q <= 1'b0;
        end else if (take) begin
          line_q[int'(count_q)*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata_i;
          if (count_q == LAST) begin
            state_q     <= DONE;
            mem_rd_q    <= 1'b0;
            fill_done_q <= 1'b1;
          end else begin
            count_q    <= count_q + 1'b1;
            mem_addr_q <= mem_addr_q + STRIDE;
          end
        end else begin
          mem_rd_q <= 1'b1;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_line_fill.sv
// tb_icache_line_fill: directed scenarios for the line-fill engine against a responsive memory model
module tb_icache_line_fill;
  bit          clk = 0;
  bit          rst = 0;
  bit          fill_req = 0;
  bit          abort = 0;
  logic [31:0] fill_addr = '0;
  logic        mem_rd, mem_valid, busy, fill_done;
  logic [31:0] mem_addr, mem_rdata;
  logic [255:0] line_data;
  int          wait_cyc = 0;
  int          wcnt = 0;
  int          passed = 0;
  int          total = 0;

  icache_line_fill dut (
    .clk_i(clk), .rst_i(rst), .fill_req_i(fill_req), .fill_addr_i(fill_addr), .abort_i(abort),
    .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata), .mem_valid_i(mem_valid),
    .busy_o(busy), .fill_done_o(fill_done), .line_data_o(line_data)
  );

  always #5 clk = ~clk;

  // memory returns its own address as data, wait_cyc cycles after the request appears
  assign mem_valid = mem_rd && (wcnt >= wait_cyc);
  assign mem_rdata = mem_addr;
  always @(posedge clk or posedge rst) wcnt <= (rst || mem_valid || !mem_rd) ? 0 : wcnt + 1;

  function automatic logic [255:0] line_of(input logic [31:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = b + 32'(4 * i);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    total++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd got %0b want 0", mem_rd); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
    total++; if (fill_done !== 1'b0) $display("FAIL reset_fill_done got %0b want 0", fill_done); else passed++;
    total++; if (line_data !== 256'd0) $display("FAIL reset_line_data got %h want 0", line_data); else passed++;
    total++; if (mem_addr !== 32'd0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else passed++;
    step();
  endtask

  task automatic test_zero_wait();
    int idx = 0, done_cyc = -1, bad = 0;
    wait_cyc = 0;
    fill_addr = 32'h134; fill_req = 1;
    step();
    fill_req = 0; fill_addr = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_rd) begin
        if (mem_addr !== 32'h120 + 32'(4 * idx)) bad++;
        idx++;
      end
      if (fill_done) begin done_cyc = c; break; end
      step();
    end
    total++; if (done_cyc != 10) $display("FAIL zw_latency got %0d want 10", done_cyc); else passed++;
    total++; if (idx != 8) $display("FAIL zw_read_cycles got %0d want 8", idx); else passed++;
    total++; if (bad != 0) $display("FAIL zw_addr_seq got %0d bad want 0", bad); else passed++;
    total++; if (line_data[31:0] !== 32'h120) $display("FAIL zw_word0 got %h want 120", line_data[31:0]); else passed++;
    total++; if (line_data[255:224] !== 32'h13C) $display("FAIL zw_word7 got %h want 13c", line_data[255:224]); else passed++;
    total++; if (line_data !== line_of(32'h120)) $display("FAIL zw_line got %h want %h", line_data, line_of(32'h120)); else passed++;
    step();
    total++; if (fill_done !== 1'b0) $display("FAIL zw_pulse_width got %0b want 0", fill_done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL zw_idle_after got busy %0b want 0", busy); else passed++;
  endtask

  task automatic test_wait_state();
    int words = 0, rd_cycles = 0, pulses = 0, bad = 0;
    wait_cyc = 3;
    fill_addr = 32'h10C; fill_req = 1;
    step();
    fill_req = 0;
    for (int c = 1; c < 60; c++) begin
      if (mem_rd) begin
        rd_cycles++;
        if (mem_addr !== 32'h100 + 32'(4 * words)) bad++;
        if (mem_valid) words++;
      end
      if (fill_done) pulses++;
      step();
    end
    total++; if (rd_cycles != 32) $display("FAIL ws_rd_cycles got %0d want 32", rd_cycles); else passed++;
    total++; if (bad != 0) $display("FAIL ws_addr_stable got %0d bad want 0", bad); else passed++;
    total++; if (words != 8) $display("FAIL ws_words got %0d want 8", words); else passed++;
    total++; if (pulses != 1) $display("FAIL ws_done_pulses got %0d want 1", pulses); else passed++;
    total++; if (line_data !== line_of(32'h100)) $display("FAIL ws_line got %h want %h", line_data, line_of(32'h100)); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ws_idle_after got busy %0b want 0", busy); else passed++;
  endtask

  task automatic test_abort();
    int bad = 0;
    bit found = 0;
    wait_cyc = 0;
    fill_addr = 32'h300; fill_req = 1;
    step();
    fill_req = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_rd && mem_addr === 32'h30C) begin found = 1; break; end
      step();
    end
    total++; if (!found) $display("FAIL ab_reach_word3 got timeout want mem_addr 30c"); else passed++;
    abort = 1;
    step();
    abort = 0;
    total++; if (busy !== 1'b0) $display("FAIL ab_busy got %0b want 0", busy); else passed++;
    total++; if (mem_rd !== 1'b0) $display("FAIL ab_mem_rd got %0b want 0", mem_rd); else passed++;
    total++; if (line_data[127:96] !== 32'h10C) $display("FAIL ab_word3_discarded got %h want 10c", line_data[127:96]); else passed++;
    total++; if (line_data[95:64] !== 32'h308) $display("FAIL ab_word2 got %h want 308", line_data[95:64]); else passed++;
    for (int c = 0; c < 12; c++) begin
      if (fill_done || mem_rd) bad++;
      step();
    end
    total++; if (bad != 0) $display("FAIL ab_quiet got %0d active cycles want 0", bad); else passed++;
    fill_addr = 32'h200; fill_req = 1;
    step();
    fill_req = 0;
    step();
    total++; if (!(mem_rd === 1'b1 && mem_addr === 32'h200)) $display("FAIL ab_restart got rd %0b addr %h want rd 1 addr 200", mem_rd, mem_addr); else passed++;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (fill_done) begin found = 1; break; end
      step();
    end
    total++; if (!found || line_data !== line_of(32'h200)) $display("FAIL ab_refill got done %0b line %h want done 1 line %h", found, line_data, line_of(32'h200)); else passed++;
    step();
  endtask

  task automatic test_ignored_req();
    int pulses = 0, bad = 0;
    wait_cyc = 1;
    fill_addr = 32'h100; fill_req = 1;
    step();
    fill_req = 0;
    repeat (3) step();
    fill_addr = 32'h400; fill_req = 1;
    step();
    fill_req = 0; fill_addr = 32'h0;
    for (int c = 0; c < 40; c++) begin
      if (mem_rd && (mem_addr < 32'h100 || mem_addr > 32'h11C)) bad++;
      if (fill_done) pulses++;
      step();
    end
    total++; if (pulses != 1) $display("FAIL ig_done_pulses got %0d want 1", pulses); else passed++;
    total++; if (bad != 0) $display("FAIL ig_addr_range got %0d stray want 0", bad); else passed++;
    total++; if (line_data !== line_of(32'h100)) $display("FAIL ig_line got %h want %h", line_data, line_of(32'h100)); else passed++;
    total++; if (busy !== 1'b0 || mem_rd !== 1'b0) $display("FAIL ig_idle_after got busy %0b rd %0b want 0 0", busy, mem_rd); else passed++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    bit found = 0;
    wait_cyc = 0;
    fill_addr = 32'h100; fill_req = 1;
    step();
    fill_req = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_rd && mem_addr === 32'h114) begin found = 1; break; end
      step();
    end
    total++; if (!found) $display("FAIL rm_reach_word5 got timeout want mem_addr 114"); else passed++;
    #2 rst = 1;
    #1;
    total++; if (mem_rd !== 1'b0) $display("FAIL rm_mem_rd got %0b want 0", mem_rd); else passed++;
    total++; if (line_data !== 256'd0) $display("FAIL rm_line_data got %h want 0", line_data); else passed++;
    total++; if (busy !== 1'b0 || mem_addr !== 32'd0) $display("FAIL rm_state got busy %0b addr %h want 0 0", busy, mem_addr); else passed++;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int c = 0; c < 8; c++) begin
      if (fill_done) pulses++;
      step();
    end
    total++; if (pulses != 0 || busy !== 1'b0) $display("FAIL rm_no_done got %0d pulses busy %0b want 0 0", pulses, busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_state();
    test_abort();
    test_ignored_req();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
